modu_exp: RTL and testbench
===========================

Name: modu_exp

Overview:
- Sequential modular exponentiator. Computes result = base^exp mod m with right-to-left binary square-and-multiply.
- Owns one instance of the serial modular multiplier modu_mul_128 and sequences it. It is the stage directly downstream of the multiplier: it issues multiplier strobes and consumes multiplier results.
- It sits between the Wishbone register file and the multiplier, and is the RSA encrypt/decrypt core.

Parameters:
- NLEN, 32, operand width in bits of base, exp, m and result. Passed through unchanged to the multiplier.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request. Operands are sampled on the same edge.
- base  input  NLEN  message or ciphertext. Any value is allowed, including base >= m.
- exp  input  NLEN  exponent.
- m  input  NLEN  modulus.
- result  output  NLEN  base^exp mod m. Held until the next accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result and error are valid.
- error  output  1  set when m == 0. Held with result.

Behaviour:
- Reset: already decided, one clock; reset is asynchronous and active-low. While rst_n is low:
  - result=0, busy=0, done=0, error=0.
  - FSM goes to IDLE and all internal registers clear.
  - The multiplier instance shares rst_n.
  - Reset mid-operation aborts immediately with no done pulse. The first start after release behaves normally.
- Multiplier contract:
  - Pulse mul_strobe for exactly one cycle with mul_x, mul_y and mul_m stable.
  - Wait for mul_ready; capture mul_p on the cycle mul_ready=1.
  - Never strobe while the multiplier is busy.
  - mul_x must be < m. Latency depends on the bit-length of mul_y, so the FSM never assumes a fixed latency.
- Registers: e_reg (remaining exponent), b_reg (running square), r_reg (accumulator), m_reg (modulus).
- FSM states: IDLE, REDUCE, WAIT_RED, CHECK, MUL, WAIT_MUL, SQR, WAIT_SQR, FINISH.
- IDLE: start=1 captures the operands and sets busy=1 on the next edge. start while busy=1 is ignored, with no effect on any state.
  - m_reg == 0: go to FINISH with error=1 and result 0.
  - m_reg == 1: go to FINISH with result 0.
  - Otherwise go to REDUCE.
- REDUCE: strobe mul(x=1, y=base) to compute base mod m. This is valid for any base because x=1 < m. On ready, b_reg <= mul_p, r_reg <= 1, then go to CHECK.
- CHECK:
  - e_reg == 0: go to FINISH, result = r_reg.
  - e_reg[0] == 1: go to MUL.
  - Otherwise go to SQR.
- MUL: strobe mul(x=r_reg, y=b_reg). On ready, r_reg <= mul_p.
  - If e_reg[NLEN-1:1] == 0: go to FINISH. The final square is skipped.
  - Otherwise go to SQR.
- SQR: strobe mul(x=b_reg, y=b_reg). On ready, b_reg <= mul_p and e_reg <= e_reg >> 1, then go to CHECK.
- FINISH: result <= r_reg (or 0 on the special cases), done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
  - A start in the cycle after done is accepted.
- Invariant: r_reg < m and b_reg < m at all times after REDUCE. All widths are NLEN and there is no overflow path.
- exp=0 with m>1 gives result=1.
- Multiplies issued: 1 (REDUCE) + popcount(exp) + (bitlen(exp) - 1) squares.

Decomposition:
- Shared package modu_pkg holds:
  - the FSM state encoding (4-bit localparams for the nine states);
  - the NLEN default (32).
- One sub-module: modu_mul_128, instantiated once as u_mul with NLEN passed through. No other sub-modules.

Test Plan:
- Basic: base=4, exp=13, m=497, start -> done pulse, result=445, error=0, busy low after done.
- RSA vector: base=65, exp=17, m=3233 -> result=2790. Decrypt with base=2790, exp=413, m=3233 -> result=65.
- Unreduced base and edge exponents:
  - base=10, exp=3, m=7 -> result=6.
  - base=5, exp=0, m=7 -> result=1.
  - base=0, exp=5, m=7 -> result=0.
- Degenerate modulus:
  - m=1, base=9, exp=4 -> result=0, error=0.
  - m=0 -> done within 3 cycles, result=0, error=1.
- Protocol:
  - Second start (base=2, exp=2, m=5) pulsed mid-operation of the first test -> ignored, result=445.
  - Back-to-back start the cycle after done -> accepted.
- Reset mid-op: assert rst_n=0 during the SQR wait of the RSA vector -> all outputs 0, no done. After release, base=3, exp=4, m=11 -> result=4.

Source files
------------

// File: rtl/modu_pkg.sv
// Shared definitions for the modular exponentiator: default operand width and FSM encoding.
package modu_pkg;

    localparam int NLEN_DEF = 32;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_REDUCE   = 4'd1;
    localparam logic [3:0] ST_WAIT_RED = 4'd2;
    localparam logic [3:0] ST_CHECK    = 4'd3;
    localparam logic [3:0] ST_MUL      = 4'd4;
    localparam logic [3:0] ST_WAIT_MUL = 4'd5;
    localparam logic [3:0] ST_SQR      = 4'd6;
    localparam logic [3:0] ST_WAIT_SQR = 4'd7;
    localparam logic [3:0] ST_FINISH   = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE     = ST_IDLE,
        S_REDUCE   = ST_REDUCE,
        S_WAIT_RED = ST_WAIT_RED,
        S_CHECK    = ST_CHECK,
        S_MUL      = ST_MUL,
        S_WAIT_MUL = ST_WAIT_MUL,
        S_SQR      = ST_SQR,
        S_WAIT_SQR = ST_WAIT_SQR,
        S_FINISH   = ST_FINISH
    } state_t;

endpackage

// File: rtl/modu_mul_128.sv
// Serial modular multiplier p = x*y mod m (x < m), one bit of y per cycle, LSB first.
// Latency bitlen(y)+2 cycles from strobe to ready; strobes while busy are ignored.
module modu_mul_128
    import modu_pkg::*;
#(
    parameter int NLEN = NLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            strobe,
    input  logic [NLEN-1:0] x,
    input  logic [NLEN-1:0] y,
    input  logic [NLEN-1:0] m,
    output logic            ready,
    output logic [NLEN-1:0] p,
    output logic            busy
);

    logic            busy_q,  busy_d;
    logic            ready_q, ready_d;
    logic [NLEN-1:0] acc_q,   acc_d;
    logic [NLEN-1:0] a_q,     a_d;
    logic [NLEN-1:0] y_q,     y_d;
    logic [NLEN-1:0] m_q,     m_d;
    logic [NLEN-1:0] p_q,     p_d;

    // acc and a are both < m, so one conditional subtract keeps each sum reduced.
    logic [NLEN:0]   m_ext, sum, dbl;
    logic [NLEN-1:0] sum_red, dbl_red;

    assign m_ext   = {1'b0, m_q};
    assign sum     = {1'b0, acc_q} + {1'b0, a_q};
    assign dbl     = {a_q, 1'b0};
    assign sum_red = (sum >= m_ext) ? NLEN'(sum - m_ext) : sum[NLEN-1:0];
    assign dbl_red = (dbl >= m_ext) ? NLEN'(dbl - m_ext) : dbl[NLEN-1:0];

    always_comb begin
        busy_d  = busy_q;
        ready_d = 1'b0;
        acc_d   = acc_q;
        a_d     = a_q;
        y_d     = y_q;
        m_d     = m_q;
        p_d     = p_q;
        if (busy_q) begin
            if (y_q == '0) begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                p_d     = acc_q;
            end else begin
                if (y_q[0]) acc_d = sum_red;
                a_d = dbl_red;
                y_d = y_q >> 1;
            end
        end else if (strobe) begin
            busy_d = 1'b1;
            acc_d  = '0;
            a_d    = x;
            y_d    = y;
            m_d    = m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            acc_q   <= '0;
            a_q     <= '0;
            y_q     <= '0;
            m_q     <= '0;
            p_q     <= '0;
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            y_q     <= y_d;
            m_q     <= m_d;
            p_q     <= p_d;
        end
    end

    assign ready = ready_q;
    assign p     = p_q;
    assign busy  = busy_q;

endmodule

// File: rtl/modu_exp.sv
// Modular exponentiator: result = base^exp mod m by right-to-left square-and-multiply.
// Latency data-dependent; done pulses one cycle; start is ignored while busy.
module modu_exp
    import modu_pkg::*;
#(
    parameter int NLEN = NLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NLEN-1:0] base,
    input  logic [NLEN-1:0] exp,
    input  logic [NLEN-1:0] m,
    output logic [NLEN-1:0] result,
    output logic            busy,
    output logic            done,
    output logic            error
);

    state_t          state_q, state_d;
    logic [NLEN-1:0] e_q, e_d;
    logic [NLEN-1:0] b_q, b_d;
    logic [NLEN-1:0] r_q, r_d;
    logic [NLEN-1:0] m_q, m_d;
    logic [NLEN-1:0] base_q, base_d;
    logic [NLEN-1:0] result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic            mul_strobe, mul_ready, mul_busy;
    logic [NLEN-1:0] mul_x, mul_y, mul_p;

    modu_mul_128 #(.NLEN(NLEN)) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (mul_strobe),
        .x      (mul_x),
        .y      (mul_y),
        .m      (m_q),
        .ready  (mul_ready),
        .p      (mul_p),
        .busy   (mul_busy)
    );

    // Operands are held across both the strobe state and its wait state.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        unique case (state_q)
            S_REDUCE, S_WAIT_RED: begin mul_x = NLEN'(1); mul_y = base_q; end
            S_MUL,    S_WAIT_MUL: begin mul_x = r_q;      mul_y = b_q;    end
            S_SQR,    S_WAIT_SQR: begin mul_x = b_q;      mul_y = b_q;    end
            default:              ;
        endcase
    end

    assign mul_strobe = ((state_q == S_REDUCE) || (state_q == S_MUL) || (state_q == S_SQR))
                        && !mul_busy;

    always_comb begin
        state_d  = state_q;
        e_d      = e_q;
        b_d      = b_q;
        r_d      = r_q;
        m_d      = m_q;
        base_d   = base_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base;
                    e_d     = exp;
                    m_d     = m;
                    b_d     = '0;
                    r_d     = '0;
                    busy_d  = 1'b1;
                    state_d = (m <= NLEN'(1)) ? S_FINISH : S_REDUCE;
                end
            end
            S_REDUCE: if (mul_strobe) state_d = S_WAIT_RED;
            S_WAIT_RED: begin
                if (mul_ready) begin
                    b_d     = mul_p;
                    r_d     = NLEN'(1);
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (e_q == '0)    state_d = S_FINISH;
                else if (e_q[0])  state_d = S_MUL;
                else              state_d = S_SQR;
            end
            S_MUL: if (mul_strobe) state_d = S_WAIT_MUL;
            S_WAIT_MUL: begin
                if (mul_ready) begin
                    r_d     = mul_p;
                    state_d = (e_q[NLEN-1:1] == '0) ? S_FINISH : S_SQR;
                end
            end
            S_SQR: if (mul_strobe) state_d = S_WAIT_SQR;
            S_WAIT_SQR: begin
                if (mul_ready) begin
                    b_d     = mul_p;
                    e_d     = e_q >> 1;
                    state_d = S_CHECK;
                end
            end
            S_FINISH: begin
                // r_q is still zero on the m <= 1 shortcut.
                result_d = r_q;
                error_d  = (m_q == '0);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            e_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            m_q      <= '0;
            base_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            b_q      <= b_d;
            r_q      <= r_d;
            m_q      <= m_d;
            base_q   <= base_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;

endmodule

// File: tb/tb_modu_exp.sv
// Directed bench for modu_exp: known modular-exponentiation vectors, protocol and reset cases.
module tb_modu_exp;
    import modu_pkg::*;

    localparam int NLEN   = 32;
    localparam int BUDGET = 4000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [NLEN-1:0] base = '0, exp_i = '0, m_i = '0;
    logic [NLEN-1:0] result;
    logic            busy, done, error;

    int n_checks = 0;
    int n_fail   = 0;

    modu_exp #(.NLEN(NLEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .base   (base),
        .exp    (exp_i),
        .m      (m_i),
        .result (result),
        .busy   (busy),
        .done   (done),
        .error  (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp_v);
        end
    endtask

    // Drives start for one cycle from the current negedge.
    task automatic drive_start(input logic [NLEN-1:0] b, input logic [NLEN-1:0] e,
                               input logic [NLEN-1:0] mm);
        base  = b;
        exp_i = e;
        m_i   = mm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_start(input logic [NLEN-1:0] b, input logic [NLEN-1:0] e,
                            input logic [NLEN-1:0] mm);
        @(negedge clk);
        drive_start(b, e, mm);
    endtask

    // Returns at the negedge of the cycle after the done pulse.
    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        while (!done && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, ":done"}, done, 1);
        @(negedge clk);
        check({tag, ":done_one_cycle"}, done, 0);
        check({tag, ":busy_after"}, busy, 0);
    endtask

    task automatic run(input string tag, input logic [NLEN-1:0] b, input logic [NLEN-1:0] e,
                       input logic [NLEN-1:0] mm, input logic [NLEN-1:0] exp_res,
                       input logic exp_err);
        int cyc;
        do_start(b, e, mm);
        check({tag, ":busy"}, busy, 1);
        wait_done(tag, cyc);
        check({tag, ":result"}, result, exp_res);
        check({tag, ":error"}, error, exp_err);
    endtask

    initial begin
        int cyc;
        int n_done;
        #1;
        check("rst:result", result, 0);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:error", error, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run("basic", 4, 13, 497, 445, 0);
        run("rsa_enc", 65, 17, 3233, 2790, 0);
        run("rsa_dec", 2790, 413, 3233, 65, 0);
        run("unreduced", 10, 3, 7, 6, 0);
        run("exp0", 5, 0, 7, 1, 0);
        run("base0", 0, 5, 7, 0, 0);
        run("m1", 9, 4, 1, 0, 0);

        do_start(9, 4, 0);
        wait_done("m0", cyc);
        check("m0:latency_le3", (cyc <= 3), 1);
        check("m0:result", result, 0);
        check("m0:error", error, 1);

        // A start during an operation must not disturb it.
        do_start(4, 13, 497);
        repeat (8) @(negedge clk);
        check("ignore:busy", busy, 1);
        drive_start(2, 2, 5);
        wait_done("ignore", cyc);
        check("ignore:result", result, 445);
        check("ignore:error", error, 0);

        // Start issued in the cycle right after done.
        drive_start(3, 4, 11);
        check("b2b:busy", busy, 1);
        wait_done("b2b", cyc);
        check("b2b:result", result, 4);

        // Reset while waiting on a squaring.
        do_start(65, 17, 3233);
        cyc = 0;
        while (dut.state_q != S_WAIT_SQR && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check("rstmid:reached_wait_sqr", (dut.state_q == S_WAIT_SQR), 1);
        rst_n = 1'b0;
        #1;
        check("rstmid:result", result, 0);
        check("rstmid:busy", busy, 0);
        check("rstmid:done", done, 0);
        check("rstmid:error", error, 0);
        n_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("rstmid:no_done", n_done, 0);
        check("rstmid:idle_busy", busy, 0);
        run("after_rst", 3, 4, 11, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
